// File: rtl/bb_frame_scrambler.sv
// Baseband energy-dispersal scrambler feeding the APSK modulator.
// Each accepted 32-bit word is XORed with 32 consecutive outputs of the
// DVB-S2 PRBS (1 + x^14 + x^15). The PRBS restarts from the seed at every
// frame boundary. Frames longer than MAX_FRAME_WORDS are cut by forcing tlast.
// The output is a two-entry skid buffer, so data_in_tready is a plain flop.
module bb_frame_scrambler #(
    parameter int          DATA_TDATA_WIDTH  = 32,
    parameter int          MAX_FRAME_WORDS   = 2048,
    parameter int          FRAME_COUNT_WIDTH = 16,
    parameter logic [14:0] PRBS_SEED         = 15'b000000010101001
) (
    input  logic                         data_in_aclk,
    input  logic                         data_in_aresetn,
    output logic                         data_in_tready,
    input  logic [DATA_TDATA_WIDTH-1:0]  data_in_tdata,
    input  logic                         data_in_tlast,
    input  logic                         data_in_tvalid,
    input  logic                         data_out_tready,
    output logic [DATA_TDATA_WIDTH-1:0]  data_out_tdata,
    output logic                         data_out_tlast,
    output logic                         data_out_tvalid,
    input  logic                         scramble_enable,
    output logic [FRAME_COUNT_WIDTH-1:0] frame_count,
    output logic                         frame_truncated
);

    // The word counter must be able to hold MAX_FRAME_WORDS itself.
    localparam int              CNT_W   = $clog2(MAX_FRAME_WORDS + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_FRAME_WORDS);
    localparam int              PW      = DATA_TDATA_WIDTH + 15;

    typedef enum logic {
        ST_IDLE,
        ST_IN_FRAME
    } state_t;

    // Runs the LFSR for one word's worth of steps. Vector bit i holds
    // register r(i+1), so r14/r15 are bits 13/14 and "shift up" is a left
    // shift with the feedback entering at bit 0. Returns {next_state, mask}
    // with mask bit k being the output of step k.
    function automatic logic [PW-1:0] prbs_unroll(input logic [14:0] seed);
        logic [14:0]                 st;
        logic [DATA_TDATA_WIDTH-1:0] mask;
        logic                        fb;
        st   = seed;
        mask = '0;
        for (int k = 0; k < DATA_TDATA_WIDTH; k++) begin
            fb      = st[13] ^ st[14];
            mask[k] = fb;
            st      = {st[13:0], fb};
        end
        return {st, mask};
    endfunction

    // Frame tracking state
    state_t                      state_q, state_d;
    logic [14:0]                 lfsr_q, lfsr_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        frame_en_q, frame_en_d;
    logic                        trunc_q, trunc_d;
    logic [FRAME_COUNT_WIDTH-1:0] frame_count_q, frame_count_d;

    // Output register and skid register
    logic                        out_valid_q, out_valid_d;
    logic [DATA_TDATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                        out_last_q, out_last_d;
    logic                        skid_valid_q, skid_valid_d;
    logic [DATA_TDATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic                        skid_last_q, skid_last_d;
    logic                        tready_q, tready_d;

    // Combinational helpers
    logic                        accept;
    logic                        out_xfer;
    logic                        first_word;
    logic                        en_eff;
    logic [CNT_W-1:0]            cnt_eff;
    logic                        at_max;
    logic                        frame_end;
    logic [14:0]                 lfsr_adv;
    logic [DATA_TDATA_WIDTH-1:0] prbs_mask;
    logic [DATA_TDATA_WIDTH-1:0] scr_data;

    assign accept   = data_in_tvalid & tready_q;
    assign out_xfer = out_valid_q & data_out_tready;

    assign {lfsr_adv, prbs_mask} = prbs_unroll(lfsr_q);

    // Per-word view of the frame: enable is latched only on the first word,
    // and a word ends the frame on input tlast or on reaching the length cap.
    always_comb begin
        first_word = (state_q == ST_IDLE);
        en_eff     = first_word ? scramble_enable : frame_en_q;
        cnt_eff    = first_word ? CNT_W'(1) : cnt_q + CNT_W'(1);
        at_max     = (cnt_eff == MAX_CNT);
        frame_end  = data_in_tlast | at_max;
        scr_data   = data_in_tdata ^ (prbs_mask & {DATA_TDATA_WIDTH{en_eff}});
    end

    // Frame FSM next state, LFSR advance/reload and truncation pulse.
    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        cnt_d      = cnt_q;
        frame_en_d = frame_en_q;
        trunc_d    = 1'b0;
        if (accept) begin
            frame_en_d = en_eff;
            trunc_d    = at_max & ~data_in_tlast;
            if (frame_end) begin
                state_d = ST_IDLE;
                lfsr_d  = PRBS_SEED;
                cnt_d   = '0;
            end else begin
                state_d = ST_IN_FRAME;
                lfsr_d  = lfsr_adv;
                cnt_d   = cnt_eff;
            end
        end
    end

    // Skid buffer steering: the skid only fills when the output register is
    // stalled, and it always drains into the output register first.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_last_d  = skid_last_q;
        if (skid_valid_q) begin
            // tready is low here, so no new word can arrive this cycle.
            if (out_xfer) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_last_d   = skid_last_q;
                skid_valid_d = 1'b0;
            end
        end else if (!out_valid_q || out_xfer) begin
            out_valid_d = accept;
            if (accept) begin
                out_data_d = scr_data;
                out_last_d = frame_end;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = scr_data;
            skid_last_d  = frame_end;
        end
        tready_d = ~skid_valid_d;
    end

    // Completed-frame counter, advanced when a tlast word leaves.
    always_comb begin
        frame_count_d = frame_count_q;
        if (out_xfer && out_last_q) begin
            frame_count_d = frame_count_q + FRAME_COUNT_WIDTH'(1);
        end
    end

    // State registers; reset clears everything and loads the PRBS seed.
    always_ff @(posedge data_in_aclk or negedge data_in_aresetn) begin
        if (!data_in_aresetn) begin
            state_q       <= ST_IDLE;
            lfsr_q        <= PRBS_SEED;
            cnt_q         <= '0;
            frame_en_q    <= 1'b0;
            trunc_q       <= 1'b0;
            frame_count_q <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_last_q    <= 1'b0;
            skid_valid_q  <= 1'b0;
            skid_data_q   <= '0;
            skid_last_q   <= 1'b0;
            tready_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            cnt_q         <= cnt_d;
            frame_en_q    <= frame_en_d;
            trunc_q       <= trunc_d;
            frame_count_q <= frame_count_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_last_q    <= out_last_d;
            skid_valid_q  <= skid_valid_d;
            skid_data_q   <= skid_data_d;
            skid_last_q   <= skid_last_d;
            tready_q      <= tready_d;
        end
    end

    assign data_in_tready  = tready_q;
    assign data_out_tvalid = out_valid_q;
    assign data_out_tdata  = out_data_q;
    assign data_out_tlast  = out_last_q;
    assign frame_count     = frame_count_q;
    assign frame_truncated = trunc_q;

endmodule

// File: tb/tb_bb_frame_scrambler.sv
// Bench for bb_frame_scrambler with a short frame cap and a narrow frame
// counter so truncation and counter wrap both occur.
module tb_bb_frame_scrambler;

    localparam int DW   = 32;
    localparam int MAXW = 4;
    localparam int FCW  = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           data_in_tready;
    logic [DW-1:0]  data_in_tdata;
    logic           data_in_tlast;
    logic           data_in_tvalid;
    logic           data_out_tready;
    logic [DW-1:0]  data_out_tdata;
    logic           data_out_tlast;
    logic           data_out_tvalid;
    logic           scramble_enable;
    logic [FCW-1:0] frame_count;
    logic           frame_truncated;

    bb_frame_scrambler #(
        .DATA_TDATA_WIDTH (DW),
        .MAX_FRAME_WORDS  (MAXW),
        .FRAME_COUNT_WIDTH(FCW),
        .PRBS_SEED        (15'b000000010101001)
    ) dut (
        .data_in_aclk    (clk),
        .data_in_aresetn (rst_n),
        .data_in_tready  (data_in_tready),
        .data_in_tdata   (data_in_tdata),
        .data_in_tlast   (data_in_tlast),
        .data_in_tvalid  (data_in_tvalid),
        .data_out_tready (data_out_tready),
        .data_out_tdata  (data_out_tdata),
        .data_out_tlast  (data_out_tlast),
        .data_out_tvalid (data_out_tvalid),
        .scramble_enable (scramble_enable),
        .frame_count     (frame_count),
        .frame_truncated (frame_truncated)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit       prbs_bits [32*MAXW];
    beat_t    exp_q[$];
    beat_t    got_q[$];
    int       n_xfer;
    int       occ;
    logic [FCW-1:0] fc_model;
    bit       trunc_exp;
    bit       stalled_prev;
    logic [DW-1:0] prev_d;
    logic     prev_l;
    bit       m_in;
    bit       m_en;
    int       m_n;
    bit       last_acc;
    int       prot_bad;
    int       trunc_bad;
    int       fc_bad;
    int       trunc_pulses;

    // PRBS stream from the register description: out = r14^r15,
    // registers shift up by one, r1 takes the output.
    task automatic init_prbs();
        int seed_list [15] = '{1,0,0,1,0,1,0,1,0,0,0,0,0,0,0};
        int r [1:15];
        int o;
        for (int j = 1; j <= 15; j++) r[j] = seed_list[j-1];
        for (int i = 0; i < 32*MAXW; i++) begin
            o = r[14] ^ r[15];
            for (int j = 15; j >= 2; j--) r[j] = r[j-1];
            r[1] = o;
            prbs_bits[i] = (o != 0);
        end
    endtask

    function automatic logic [DW-1:0] mask_word(input int n);
        logic [DW-1:0] m;
        m = '0;
        for (int k = 0; k < DW; k++) m[k] = prbs_bits[32*n + k];
        return m;
    endfunction

    task automatic model_accept(input logic [DW-1:0] d, input bit l, input bit se);
        beat_t e;
        if (!m_in) begin
            m_en = se;
            m_n  = 0;
        end
        e.data = d ^ (m_en ? mask_word(m_n) : '0);
        m_n++;
        e.last    = l || (m_n == MAXW);
        trunc_exp = !l && (m_n == MAXW);
        m_in      = !e.last;
        exp_q.push_back(e);
    endtask

    // One clock: drive at the falling edge, observe 1 time unit later,
    // then update the model with what the next rising edge will do.
    task automatic step(input bit iv, input logic [DW-1:0] id, input bit il,
                        input bit se, input bit ordy);
        bit xfer;
        @(negedge clk);
        data_in_tvalid  = iv;
        data_in_tdata   = id;
        data_in_tlast   = il;
        scramble_enable = se;
        data_out_tready = ordy;
        #1;
        if (data_in_tready !== (occ < 2)) prot_bad++;
        if (data_out_tvalid !== (occ > 0)) prot_bad++;
        if (stalled_prev && (data_out_tvalid !== 1'b1 || data_out_tdata !== prev_d ||
                             data_out_tlast !== prev_l)) prot_bad++;
        if (frame_truncated !== trunc_exp) trunc_bad++;
        if (frame_count !== fc_model) fc_bad++;
        if (frame_truncated === 1'b1) trunc_pulses++;
        last_acc  = iv && (data_in_tready === 1'b1);
        xfer      = (data_out_tvalid === 1'b1) && ordy;
        trunc_exp = 1'b0;
        if (xfer) begin
            got_q.push_back({data_out_tlast, data_out_tdata});
            if (n_xfer < exp_q.size() && exp_q[n_xfer].last) fc_model++;
            n_xfer++;
            if (occ > 0) occ--;
        end
        if (last_acc) begin
            model_accept(id, il, se);
            occ++;
        end
        stalled_prev = (data_out_tvalid === 1'b1) && !ordy;
        prev_d       = data_out_tdata;
        prev_l       = data_out_tlast;
    endtask

    task automatic send(input logic [DW-1:0] d, input bit l, input bit se,
                        input bit rnd, output int tries);
        tries = 0;
        do begin
            step(1'b1, d, l, se, rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            tries++;
        end while (!last_acc && tries < 100);
    endtask

    // Empties the DUT, plus one extra cycle so frame_count has settled.
    task automatic drain(output bit ok);
        int n = 0;
        while (occ > 0 && n < 200) begin
            step(1'b0, '0, 1'b0, 1'b1, 1'b1);
            n++;
        end
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        ok = (occ == 0);
    endtask

    task automatic clear_sb();
        exp_q.delete();
        got_q.delete();
        n_xfer = 0;
    endtask

    task automatic do_reset();
        data_in_tvalid  = 1'b0;
        data_in_tdata   = '0;
        data_in_tlast   = 1'b0;
        data_out_tready = 1'b0;
        rst_n           = 1'b0;
        clear_sb();
        occ = 0; fc_model = '0; trunc_exp = 0; stalled_prev = 0;
        m_in = 0; m_n = 0; m_en = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({data_out_tvalid, data_out_tlast, data_in_tready, frame_truncated} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 0000",
                     {data_out_tvalid, data_out_tlast, data_in_tready, frame_truncated});
        end
        checks++;
        if (data_out_tdata !== '0 || frame_count !== '0) begin
            errors++;
            $display("FAIL reset_data tdata=%h frame_count=%0d want 0/0", data_out_tdata, frame_count);
        end
        do_reset();
        #1;
        checks++;
        if (data_in_tready !== 1'b0) begin
            errors++;
            $display("FAIL reset_tready_early got %b want 0", data_in_tready);
        end
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (data_in_tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_tready_rise got %b want 1", data_in_tready);
        end
    endtask

    task automatic test_single_word();
        clear_sb();
        step(1'b1, 32'h0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (!last_acc) begin
            errors++;
            $display("FAIL single_accept got 0 want 1");
        end
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (data_out_tvalid !== 1'b1 || data_out_tlast !== 1'b1 || data_out_tdata[14:0] !== 15'h6FC0) begin
            errors++;
            $display("FAIL single_word valid=%b last=%b low15=%h want 1/1/6fc0",
                     data_out_tvalid, data_out_tlast, data_out_tdata[14:0]);
        end
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (frame_count !== 4'd1) begin
            errors++;
            $display("FAIL single_frame_count got %0d want 1", frame_count);
        end
        checks++;
        if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL single_model got %0d beats want 1 matching model", got_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int tries;
        int slow = 0;
        bit ok;
        logic [DW-1:0] vals [8];
        clear_sb();
        send(32'h0, 1'b1, 1'b1, 1'b0, tries);
        if (tries != 1) slow++;
        send(32'h0, 1'b1, 1'b1, 1'b0, tries);
        if (tries != 1) slow++;
        for (int i = 0; i < 8; i++) begin
            vals[i] = $urandom;
            send(vals[i], i == 7, 1'b1, 1'b0, tries);
            if (tries != 1) slow++;
        end
        drain(ok);
        checks++;
        if (!ok || slow != 0) begin
            errors++;
            $display("FAIL b2b_throughput stalled_words=%0d drained=%0d want 0/1", slow, ok);
        end
        checks++;
        if (got_q.size() != 10) begin
            errors++;
            $display("FAIL b2b_count got %0d want 10", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== got_q[1] || got_q[0].data[14:0] !== 15'h6FC0) begin
                errors++;
                $display("FAIL b2b_reseed first=%h second=%h want equal, low15 6fc0",
                         got_q[0].data, got_q[1].data);
            end
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL b2b_word%0d got %h want %h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] vals [4];
        int tries;
        bit ok;
        vals[0] = 32'h12345678; vals[1] = 32'h9ABCDEF0;
        vals[2] = 32'hFFFFFFFF; vals[3] = 32'h00000001;
        clear_sb();
        // Enable rises after the first word; the frame must stay in bypass.
        for (int i = 0; i < 4; i++) send(vals[i], i == 3, i != 0, 1'b0, tries);
        drain(ok);
        checks++;
        if (!ok || got_q.size() != 4) begin
            errors++;
            $display("FAIL bypass_count got %0d want 4", got_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_q[i].data !== vals[i] || got_q[i].last !== (i == 3)) begin
                    errors++;
                    $display("FAIL bypass_word%0d got %h/%b want %h/%b",
                             i, got_q[i].data, got_q[i].last, vals[i], i == 3);
                end
            end
        end
    endtask

    task automatic test_random_stall();
        int tries;
        int bad = 0;
        bit ok;
        clear_sb();
        for (int i = 0; i < 64; i++) begin
            send($urandom, i == 63, 1'($urandom_range(0, 1)), 1'b1, tries);
            if (!last_acc) bad++;
        end
        drain(ok);
        checks++;
        if (!ok || bad != 0) begin
            errors++;
            $display("FAIL random_timeout unaccepted=%0d drained=%0d want 0/1", bad, ok);
        end
        checks++;
        if (got_q.size() != 64 || exp_q.size() != 64) begin
            errors++;
            $display("FAIL random_count got %0d want 64", got_q.size());
        end else begin
            bad = 0;
            for (int i = 0; i < 64; i++) if (got_q[i] !== exp_q[i]) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL random_data mismatched_words got %0d want 0", bad);
            end
        end
    endtask

    task automatic test_max_len();
        logic [DW-1:0] vals [6];
        logic [FCW-1:0] fc0;
        int tries;
        bit ok;
        clear_sb();
        fc0 = fc_model;
        trunc_pulses = 0;
        for (int i = 0; i < 6; i++) begin
            vals[i] = $urandom;
            send(vals[i], i == 5, 1'b1, 1'b0, tries);
        end
        drain(ok);
        checks++;
        if (!ok || got_q.size() != 6) begin
            errors++;
            $display("FAIL maxlen_count got %0d want 6", got_q.size());
        end else begin
            checks++;
            if ({got_q[5].last, got_q[4].last, got_q[3].last, got_q[2].last,
                 got_q[1].last, got_q[0].last} !== 6'b101000) begin
                errors++;
                $display("FAIL maxlen_tlast got %b want 101000",
                         {got_q[5].last, got_q[4].last, got_q[3].last, got_q[2].last,
                          got_q[1].last, got_q[0].last});
            end
            checks++;
            if ((got_q[4].data ^ vals[4]) !== mask_word(0) || (got_q[3].data ^ vals[3]) !== mask_word(3)) begin
                errors++;
                $display("FAIL maxlen_reseed word5 mask %h want %h", got_q[4].data ^ vals[4], mask_word(0));
            end
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL maxlen_word%0d got %h want %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (trunc_pulses != 1) begin
            errors++;
            $display("FAIL maxlen_trunc_pulses got %0d want 1", trunc_pulses);
        end
        checks++;
        if (frame_count !== FCW'(fc0 + 2)) begin
            errors++;
            $display("FAIL maxlen_frame_count got %0d want %0d", frame_count, FCW'(fc0 + 2));
        end
        // tlast exactly on the cap is a normal end.
        clear_sb();
        trunc_pulses = 0;
        for (int i = 0; i < 4; i++) send($urandom, i == 3, 1'b1, 1'b0, tries);
        drain(ok);
        checks++;
        if (trunc_pulses != 0 || got_q.size() != 4 || got_q[3].last !== 1'b1) begin
            errors++;
            $display("FAIL maxlen_exact pulses=%0d beats=%0d want 0/4", trunc_pulses, got_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int tries;
        bit ok;
        clear_sb();
        send($urandom, 1'b0, 1'b1, 1'b0, tries);
        data_out_tready = 1'b0;
        step(1'b1, $urandom, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (data_in_tready !== 1'b0 || data_out_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_full tready=%b tvalid=%b want 0/1", data_in_tready, data_out_tvalid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({data_out_tvalid, data_out_tlast, data_in_tready, frame_truncated} !== 4'b0 ||
            data_out_tdata !== '0 || frame_count !== '0) begin
            errors++;
            $display("FAIL midrst_clear ctrl=%b tdata=%h fc=%0d want 0",
                     {data_out_tvalid, data_out_tlast, data_in_tready, frame_truncated},
                     data_out_tdata, frame_count);
        end
        do_reset();
        send(32'h0, 1'b1, 1'b1, 1'b0, tries);
        drain(ok);
        checks++;
        if (!ok || got_q.size() != 1 || got_q[0].data[14:0] !== 15'h6FC0 ||
            got_q[0].data !== mask_word(0) || got_q[0].last !== 1'b1) begin
            errors++;
            $display("FAIL midrst_seed beats=%0d data=%h want 1 beat %h",
                     got_q.size(), got_q.size() > 0 ? got_q[0].data : '0, mask_word(0));
        end
    endtask

    task automatic test_protocol();
        checks++;
        if (prot_bad != 0) begin
            errors++;
            $display("FAIL protocol violations got %0d want 0", prot_bad);
        end
        checks++;
        if (trunc_bad != 0) begin
            errors++;
            $display("FAIL trunc_timing violations got %0d want 0", trunc_bad);
        end
        checks++;
        if (fc_bad != 0) begin
            errors++;
            $display("FAIL frame_count_track violations got %0d want 0", fc_bad);
        end
    endtask

    initial begin
        data_in_tvalid  = 1'b0;
        data_in_tdata   = '0;
        data_in_tlast   = 1'b0;
        data_out_tready = 1'b0;
        scramble_enable = 1'b1;
        rst_n           = 1'b0;
        prot_bad = 0; trunc_bad = 0; fc_bad = 0; trunc_pulses = 0;
        init_prbs();
        test_reset();
        test_single_word();
        test_back_to_back();
        test_bypass();
        test_random_stall();
        test_max_len();
        test_reset_mid();
        test_protocol();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule
